pwm_update_scheduler: RTL and testbench



---
 rtl/pwm_update_scheduler.sv | 101 ++++++++++
 tb/tb_pwm_update_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_update_scheduler.sv
// Four-channel PWM duty scheduler: shadow duties commit atomically at the period wrap.
// Optional quarter-period channel stagger under PWM_SCHED_STAGGER_EN.
module pwm_update_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_ch,
    input  logic [7:0] wr_duty,
    input  logic       commit,
    output logic       pending,
    output logic       period_start,
    output logic [3:0] pwm_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] shadow [4];
    logic [7:0] active [4];
    logic [7:0] phase  [4];
    logic       wrapTick;

    assign wrapTick = tick && (cnt == 8'd255);
    assign wr_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= 8'd0;
            period_start <= 1'b0;
        end else begin
            if (tick) begin
                cnt <= cnt + 8'd1;
            end
            period_start <= wrapTick;
        end
    end

    // A commit seen in IDLE always waits for a later wrap, even on the wrap tick itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pending <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 8'd0;
                active[i] <= 8'd0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_valid) begin
                        shadow[wr_ch] <= wr_duty;
                    end
                    if (commit) begin
                        state   <= ARMED;
                        pending <= 1'b1;
                    end
                end
                ARMED: begin
                    if (wrapTick) begin
                        for (int i = 0; i < 4; i++) begin
                            active[i] <= shadow[i];
                        end
                        state   <= IDLE;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
`ifdef PWM_SCHED_STAGGER_EN
            phase[i] = cnt + 8'(i * 64);
`else
            phase[i] = cnt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pwm_out[i] <= (phase[i] < active[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Directed bench for pwm_update_scheduler with tick held high.
// Duty checks count high samples over one full 256-count period.
module tb_pwm_update_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_ch = 2'd0;
    logic [7:0] wr_duty = 8'd0;
    logic       commit = 1'b0;
    logic       pending;
    logic       period_start;
    logic [3:0] pwm_out;

    int vectors = 0;
    int miscompares = 0;
    int hcount [4];
    int firstHigh [4];
    int n;

    pwm_update_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .commit      (commit),
        .pending     (pending),
        .period_start(period_start),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic waitPeriod(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!period_start && cycles < 600);
        if (!period_start) begin
            check("periodTimeout", 32'(cycles), 32'd0);
        end
    endtask

    // Starts on a period_start sample; sample k shows the compare for cnt k-1.
    task automatic measurePeriod();
        for (int i = 0; i < 4; i++) begin
            hcount[i] = 0;
            firstHigh[i] = -1;
        end
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (pwm_out[i]) begin
                    hcount[i]++;
                    if (firstHigh[i] < 0) firstHigh[i] = k - 1;
                end
            end
        end
    endtask

    task automatic checkDuties(input string tag, input int r, input int g,
                               input int b, input int w);
        check({tag, "_R"}, 32'(hcount[0]), 32'(r));
        check({tag, "_G"}, 32'(hcount[1]), 32'(g));
        check({tag, "_B"}, 32'(hcount[2]), 32'(b));
        check({tag, "_W"}, 32'(hcount[3]), 32'(w));
    endtask

    task automatic putWrite(input int ch, input int duty, input bit cmt);
        wr_valid = 1'b1;
        wr_ch    = 2'(ch);
        wr_duty  = 8'(duty);
        commit   = cmt;
        @(negedge clk);
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    task automatic pulseCommit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tick  = 1'b1;
        repeat (3) @(negedge clk);
        check("rstPwm", 32'(pwm_out), 32'd0);
        check("rstReady", 32'(wr_ready), 32'd1);
        check("rstPending", 32'(pending), 32'd0);
        check("rstPstart", 32'(period_start), 32'd0);
        reset = 1'b0;
        waitPeriod(n);
        check("firstWrap", 32'(n), 32'd256);
        waitPeriod(n);
        check("periodLen", 32'(n), 32'd256);
        check("idlePwm", 32'(pwm_out), 32'd0);

        putWrite(0, 64, 1'b0);
        putWrite(1, 128, 1'b0);
        putWrite(2, 255, 1'b0);
        putWrite(3, 0, 1'b0);
        pulseCommit();
        check("armPending", 32'(pending), 32'd1);
        check("armReady", 32'(wr_ready), 32'd0);
        waitPeriod(n);
        check("appliedPending", 32'(pending), 32'd0);
        measurePeriod();
        checkDuties("basic", 64, 128, 255, 0);

        pulseCommit();
        wr_valid = 1'b1;
        wr_ch    = 2'd1;
        wr_duty  = 8'd10;
        check("bpReady", 32'(wr_ready), 32'd0);
        @(negedge clk);
        wr_valid = 1'b0;
        waitPeriod(n);
        measurePeriod();
        checkDuties("bp", 64, 128, 255, 0);
        check("retryReady", 32'(wr_ready), 32'd1);
        putWrite(1, 10, 1'b0);
        waitPeriod(n);
        measurePeriod();
        checkDuties("bpRetry", 64, 128, 255, 0);

        putWrite(0, 200, 1'b1);
        check("simulPending", 32'(pending), 32'd1);
        pulseCommit();
        waitPeriod(n);
        check("simulDone", 32'(pending), 32'd0);
        measurePeriod();
        checkDuties("simul", 200, 10, 255, 0);
        putWrite(0, 5, 1'b0);
        waitPeriod(n);
        measurePeriod();
        checkDuties("noExtra", 200, 10, 255, 0);
        check("noExtraPending", 32'(pending), 32'd0);

        repeat (255) @(negedge clk);
        putWrite(0, 77, 1'b1);
        check("wrapCmtPstart", 32'(period_start), 32'd1);
        check("wrapCmtPending", 32'(pending), 32'd1);
        measurePeriod();
        checkDuties("wrapCmtOld", 200, 10, 255, 0);
        measurePeriod();
        checkDuties("wrapCmtNew", 77, 10, 255, 0);
        check("wrapCmtDone", 32'(pending), 32'd0);

        for (int i = 0; i < 4; i++) putWrite(i, 32, 1'b0);
        pulseCommit();
        waitPeriod(n);
        measurePeriod();
        checkDuties("d32", 32, 32, 32, 32);
`ifdef PWM_SCHED_STAGGER_EN
        check("rise0", 32'(firstHigh[0]), 32'd0);
        check("rise1", 32'(firstHigh[1]), 32'd192);
        check("rise2", 32'(firstHigh[2]), 32'd128);
        check("rise3", 32'(firstHigh[3]), 32'd64);
`else
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rise%0d", i), 32'(firstHigh[i]), 32'd0);
        end
`endif

        putWrite(0, 50, 1'b1);
        check("midPending", 32'(pending), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midRstPwm", 32'(pwm_out), 32'd0);
        check("midRstPending", 32'(pending), 32'd0);
        check("midRstPstart", 32'(period_start), 32'd0);
        check("midRstReady", 32'(wr_ready), 32'd1);
        reset = 1'b0;
        waitPeriod(n);
        check("midRstWrap", 32'(n), 32'd256);
        measurePeriod();
        checkDuties("midRst", 0, 0, 0, 0);
        pulseCommit();
        waitPeriod(n);
        measurePeriod();
        checkDuties("shadowLost", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
